// File: rtl/bin_to_disp_chars.sv
// ---------------------------------------------------------------------------
// bin_to_disp_chars
//   Converts a signed two's-complement value into four 4-bit character codes
//   for the multiplexed 7-segment driver: sign in char3, magnitude digits in
//   char2..char0 with leading zeros blanked. The magnitude is converted with an
//   iterative shift-add-3 (double dabble), one bit per clock.
//
//   Character codes: 0-9 digit, 10 = '-', 11 = 'F' (overflow), 12 = blank.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      conversion request, sampled only while idle
//   value      in   WIDTH  signed operand, captured on the accepting edge
//   busy       out  1      conversion in progress
//   done       out  1      one-cycle pulse, char3..char0 just updated
//   char3..0   out  4      sign, hundreds, tens, units character codes
//   dbg_state  out  2      current FSM state (IDLE/ABS/SHIFT/FORMAT)
//
// Handshake: start is a request that is honoured only when the block is idle;
// a request seen while busy is dropped, not queued. Once accepted, the block
// runs for a fixed WIDTH+2 edges and raises done for exactly one cycle on the
// edge that loads the characters. Holding start high therefore yields a new
// conversion every WIDTH+3 cycles.
// ---------------------------------------------------------------------------
module bin_to_disp_chars #(
  parameter int WIDTH   = 11,
  parameter int MAX_MAG = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       char3,
  output logic [3:0]       char2,
  output logic [3:0]       char1,
  output logic [3:0]       char0,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] C_MINUS = 4'd10;
  localparam logic [3:0] C_F     = 4'd11;
  localparam logic [3:0] C_BLANK = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ABS    = 2'd1,
    S_SHIFT  = 2'd2,
    S_FORMAT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_shift;
  logic [11:0]      r_bcd;
  logic [4:0]       r_cnt;
  logic             r_neg;
  logic             r_ovf;
  logic             r_done;
  logic [3:0]       r_c3, r_c2, r_c1, r_c0;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_mag;
  logic [11:0]      w_bcd_adj;
  logic             w_load;
  logic             w_last;
  logic [3:0]       w_c3, w_c2, w_c1, w_c0;

  // One extra bit so that negating the most negative value is exact.
  assign w_ext = {r_value[WIDTH-1], r_value};
  assign w_mag = r_value[WIDTH-1] ? -w_ext : w_ext;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 3; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  assign w_last = (r_cnt == 5'(WIDTH - 1));

  // ---- state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ABS;
      S_ABS:    w_next = S_SHIFT;
      S_SHIFT:  if (w_last) w_next = S_FORMAT;
      S_FORMAT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    busy      = (r_state != S_IDLE);
    w_load    = (r_state == S_FORMAT);
    dbg_state = r_state;
  end

  // Character formatting from the finished BCD digits.
  always_comb begin
    w_c3 = r_neg ? C_MINUS : C_BLANK;
    w_c2 = (r_bcd[11:8] == 4'd0) ? C_BLANK : r_bcd[11:8];
    w_c1 = (r_bcd[11:8] == 4'd0 && r_bcd[7:4] == 4'd0) ? C_BLANK : r_bcd[7:4];
    w_c0 = r_bcd[3:0];
    if (r_ovf) begin
      w_c3 = C_F;
      w_c2 = C_F;
      w_c1 = C_F;
      w_c0 = C_F;
    end
  end

  // ---- datapath ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_c3    <= C_BLANK;
      r_c2    <= C_BLANK;
      r_c1    <= C_BLANK;
      r_c0    <= C_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_value <= value;
        end
        S_ABS: begin
          r_neg   <= r_value[WIDTH-1];
          r_shift <= w_mag[WIDTH-1:0];
          r_ovf   <= (32'(w_mag) > 32'(MAX_MAG));
          r_bcd   <= '0;
          r_cnt   <= '0;
        end
        S_SHIFT: begin
          {r_bcd, r_shift} <= {w_bcd_adj[10:0], r_shift, 1'b0};
          // A carry out of the hundreds digit means the magnitude cannot be
          // shown in three digits; keep it as overflow.
          if (w_bcd_adj[11]) r_ovf <= 1'b1;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FORMAT: begin
          if (w_load) begin
            r_c3   <= w_c3;
            r_c2   <= w_c2;
            r_c1   <= w_c1;
            r_c0   <= w_c0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done  = r_done;
  assign char3 = r_c3;
  assign char2 = r_c2;
  assign char1 = r_c1;
  assign char0 = r_c0;

endmodule

// File: tb/tb_bin_to_disp_chars.sv
// ---------------------------------------------------------------------------
// tb_bin_to_disp_chars
//   Bench for bin_to_disp_chars (WIDTH=11, MAX_MAG=999). A timeline model
//   (countdown from acceptance to done, decimal formatting by division) is
//   compared against the DUT on every falling edge; directed tasks pin
//   latency and literal character patterns; a random phase mixes starts,
//   value changes and resets.
// ---------------------------------------------------------------------------
module tb_bin_to_disp_chars;

  localparam int WIDTH   = 11;
  localparam int MAX_MAG = 999;

  // ---- clock / reset ----
  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic [3:0]       char3, char2, char1, char0;
  logic [1:0]       dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bin_to_disp_chars #(.WIDTH(WIDTH), .MAX_MAG(MAX_MAG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .char3     (char3),
    .char2     (char2),
    .char1     (char1),
    .char0     (char0),
    .dbg_state (dbg_state)
  );

  // ---- bookkeeping ----
  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected display word {char3,char2,char1,char0} for a signed operand.
  function automatic logic [15:0] fmt(input logic [WIDTH-1:0] v);
    int iv, mag, h, t, u;
    logic [3:0] c3, c2, c1;
    iv  = int'($signed(v));
    mag = (iv < 0) ? -iv : iv;
    if (mag > MAX_MAG) return 16'hBBBB;
    h  = mag / 100;
    t  = (mag / 10) % 10;
    u  = mag % 10;
    c3 = (iv < 0) ? 4'd10 : 4'd12;
    c2 = (h == 0) ? 4'd12 : 4'(h);
    c1 = (h == 0 && t == 0) ? 4'd12 : 4'(t);
    return {c3, c2, c1, 4'(u)};
  endfunction

  // ---- reference model: countdown timeline + scoreboard ----
  int               m_cnt;
  logic [WIDTH-1:0] m_val;
  logic [15:0]      m_chars;
  logic             m_done;
  logic [15:0]      exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt   <= 0;
      m_done  <= 1'b0;
      m_chars <= 16'hCCCC;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_val <= value;
          m_cnt <= WIDTH + 2;
          exp_q.push_back(fmt(value));
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_chars <= fmt(m_val);
          m_done  <= 1'b1;
        end
      end
    end
  end

  // ---- compare process ----
  always @(negedge clk) begin
    if (checking) begin
      chk("done", done, m_done);
      chk("chars", {char3, char2, char1, char0}, m_chars);
      // The cycle right after acceptance is not checked for busy.
      if (m_cnt != WIDTH + 2) chk("busy", busy, (m_cnt != 0));
      if (done) begin
        chk("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("sb_chars", {char3, char2, char1, char0}, exp_q.pop_front());
      end
    end
  end

  // ---- driver tasks ----
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One conversion with literal expectation and exact latency check.
  task automatic run_conv(input logic [WIDTH-1:0] v, input logic [15:0] exp_lit, input string name);
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    value = WIDTH'($urandom);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    chk({name, "_latency"}, n, 13);
    chk({name, "_chars"}, {char3, char2, char1, char0}, exp_lit);
    @(posedge clk); #1;
    chk({name, "_done_single"}, done, 0);
  endtask

  int bvals[14] = '{999, -999, 1000, -1000, -1024, 1023, 0, 1, -1, 9, 10, 99, 100, -100};

  // ---- watchdog ----
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- main sequence ----
  initial begin
    int ndone, first_at, t0, t1, t2;
    reset = 1'b0;
    start = 1'b0;
    value = '0;

    // Pin the model to hand-computed patterns.
    chk("model_m194", fmt(11'h73E), 16'hA194);
    chk("model_10",   fmt(11'd10),  16'hCC10);
    chk("model_m32",  fmt(11'h7E0), 16'hAC32);
    chk("model_0",    fmt(11'd0),   16'hCCC0);
    chk("model_999",  fmt(11'd999), 16'hC999);
    chk("model_1000", fmt(11'd1000), 16'hBBBB);
    chk("model_m1024", fmt(11'h400), 16'hBBBB);

    #2 reset = 1'b1;
    checking = 1'b1;
    idle(2);
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_chars", {char3, char2, char1, char0}, 16'hCCCC);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Directed conversions.
    run_conv(11'h73E, 16'hA194, "m194");
    run_conv(11'd10,  16'hCC10, "p10");
    run_conv(11'h7E0, 16'hAC32, "m32");
    run_conv(11'd0,   16'hCCC0, "zero");
    run_conv(11'd999, 16'hC999, "p999");
    run_conv(11'd100, 16'hC100, "p100");
    run_conv(11'h419, 16'hA999, "m999");
    run_conv(11'd1000, 16'hBBBB, "p1000");
    run_conv(11'h400, 16'hBBBB, "m1024");
    run_conv(11'd1023, 16'hBBBB, "p1023");

    // Reset mid-stream: chars go blank and stay blank.
    @(posedge clk); #1;
    start = 1'b1;
    value = 11'd57;
    @(posedge clk); #1;
    start = 1'b0;
    idle(3);
    pulse_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (i == 19) chk("midrst_hold_chars", {char3, char2, char1, char0}, 16'hCCCC);
    end
    chk("midrst_no_done", ndone, 0);

    // Start pulses while busy are ignored; value changes have no effect.
    @(posedge clk); #1;
    start = 1'b1;
    value = 11'd321;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    first_at = 0;
    for (int i = 1; i <= 25; i++) begin
      start = (i == 3 || i == 8);
      value = WIDTH'($urandom);
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_at == 0) first_at = i;
      end
    end
    start = 1'b0;
    chk("ignore_ndone", ndone, 1);
    chk("ignore_latency", first_at, 13);
    chk("ignore_chars", {char3, char2, char1, char0}, 16'hC321);

    // Start held high: one conversion every 14 cycles.
    @(posedge clk); #1;
    start = 1'b1;
    t0 = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 50; i++) begin
      value = WIDTH'($urandom);
      @(posedge clk); #1;
      if (done) begin
        if (t0 == 0) t0 = i;
        else if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    start = 1'b0;
    chk("held_period1", t1 - t0, 14);
    chk("held_period2", t2 - t1, 14);
    idle(20);

    // Reset during the shift phase, then a normal conversion.
    @(posedge clk); #1;
    start = 1'b1;
    value = 11'd456;
    @(posedge clk); #1;
    start = 1'b0;
    idle(5);
    pulse_reset();
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("shiftrst_no_done", ndone, 0);
    chk("shiftrst_busy", busy, 0);
    chk("shiftrst_chars", {char3, char2, char1, char0}, 16'hCCCC);
    run_conv(11'd123, 16'hC123, "after_rst");

    // Random phase: model comparison on every cycle.
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) value = WIDTH'(bvals[$urandom_range(0, 13)]);
      else                           value = WIDTH'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        start = 1'b0;
        pulse_reset();
      end
    end
    start = 1'b0;
    idle(20);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
